// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and divide-by-zero constants for seq_alu.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ALU_ADD   = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SUB   = 4'b0001;
  localparam logic [OP_W-1:0] ALU_AND   = 4'b0010;
  localparam logic [OP_W-1:0] ALU_OR    = 4'b0011;
  localparam logic [OP_W-1:0] ALU_SLTU  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_XOR   = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SLT   = 4'b0111;
  localparam logic [OP_W-1:0] ALU_MUL   = 4'b1000;
  localparam logic [OP_W-1:0] ALU_MULHU = 4'b1001;
  localparam logic [OP_W-1:0] ALU_DIVU  = 4'b1010;
  localparam logic [OP_W-1:0] ALU_REMU  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // divu by zero sets every quotient bit; remu by zero returns the dividend
  localparam logic DIVZ_QUOT_BIT = 1'b1;

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU);
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared iteration engine: shift-add multiply and restoring divide, one bit per cycle.
// mul: {hi_o,lo_o} is the product. div: lo_o is the quotient, hi_o the remainder.
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  logic             busy_q, busy_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH-1:0] src_hi, src_lo, src_b;
  logic             src_div;
  logic [WIDTH:0]   sum, shl;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  // The first iteration is applied while loading, so WIDTH steps end WIDTH-1 edges later.
  always_comb begin
    src_hi  = hi_q;
    src_lo  = lo_q;
    src_b   = b_q;
    src_div = div_q;
    if (start_i) begin
      src_hi  = '0;
      src_lo  = a_i;
      src_b   = b_i;
      src_div = is_div_i;
    end

    sum  = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_b} : '0);
    shl  = {src_hi, src_lo[WIDTH-1]};
    ge   = (shl >= {1'b0, src_b});
    diff = shl[WIDTH-1:0] - src_b;

    if (src_div) begin
      step_hi = ge ? diff : shl[WIDTH-1:0];
      step_lo = {src_lo[WIDTH-2:0], ge};
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], src_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    done_o = busy_q && (cnt_q == CNT_W'(WIDTH));

    if (start_i) begin
      busy_d = 1'b1;
      div_d  = is_div_i;
      cnt_d  = CNT_W'(1);
      hi_d   = step_hi;
      lo_d   = step_lo;
      b_d    = b_i;
    end else if (done_o) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      hi_d  = step_hi;
      lo_d  = step_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
    end
  end

  assign lo_o = lo_q;
  assign hi_o = hi_q;

endmodule

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU with registered result.
// Iterative mul/mulhu/divu/remu only when SEQ_ALU_MULDIV_EN is defined.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  alu_selector,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             neg
);

  if (WIDTH < 4 || CNT_W < $clog2(WIDTH + 1)) begin : g_bad_param
    $error("seq_alu: WIDTH must be >= 4 and CNT_W must hold WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             accept;

  function automatic logic [WIDTH-1:0] single_op(input logic [OP_W-1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_SLTU: return WIDTH'(a < b);
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return WIDTH'($signed(a) < $signed(b));
      default:  return b;
    endcase
  endfunction

`ifdef SEQ_ALU_MULDIV_EN
  logic             hi_sel_q, hi_sel_d;
  logic             iter_start;
  logic             iter_div;
  logic             iter_done;
  logic [WIDTH-1:0] iter_lo, iter_hi;

  assign iter_div = is_div_op(alu_selector);

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (iter_start),
    .is_div_i (iter_div),
    .a_i      (in1),
    .b_i      (in2),
    .done_o   (iter_done),
    .lo_o     (iter_lo),
    .hi_o     (iter_hi)
  );
`endif

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  // Next state and result; an accepted op overrides the HOLD->IDLE return.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
`ifdef SEQ_ALU_MULDIV_EN
    hi_sel_d   = hi_sel_q;
    iter_start = 1'b0;
`endif

    case (state_q)
      ST_HOLD: if (out_ready) state_d = ST_IDLE;
`ifdef SEQ_ALU_MULDIV_EN
      ST_MUL, ST_DIV: begin
        if (iter_done) begin
          out_d   = hi_sel_q ? iter_hi : iter_lo;
          state_d = ST_HOLD;
        end
      end
`endif
      default: ;
    endcase

    if (accept) begin
`ifdef SEQ_ALU_MULDIV_EN
      if (is_mul_op(alu_selector)) begin
        iter_start = 1'b1;
        hi_sel_d   = alu_selector[0];
        state_d    = ST_MUL;
      end else if (is_div_op(alu_selector) && (in2 != '0)) begin
        iter_start = 1'b1;
        hi_sel_d   = alu_selector[0];
        state_d    = ST_DIV;
      end else if (is_div_op(alu_selector)) begin
        out_d   = (alu_selector == ALU_DIVU) ? {WIDTH{DIVZ_QUOT_BIT}} : in1;
        state_d = ST_HOLD;
      end else
`endif
      begin
        out_d   = single_op(alu_selector, in1, in2);
        state_d = ST_HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
`ifdef SEQ_ALU_MULDIV_EN
      hi_sel_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
`ifdef SEQ_ALU_MULDIV_EN
      hi_sel_q <= hi_sel_d;
`endif
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out       = out_q;
  assign zero      = ~|out_q;
  assign neg       = out_q[WIDTH-1];

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu; expectations adapt to SEQ_ALU_MULDIV_EN.
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_selector;
  logic [W-1:0] in1, in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zero, neg;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_selector (alu_selector),
    .in1          (in1),
    .in2          (in2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out          (out),
    .zero         (zero),
    .neg          (neg)
  );

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd5:  return (a < b) ? 32'd1 : 32'd0;
      4'd6:  return a ^ b;
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef SEQ_ALU_MULDIV_EN
      4'd8:  return p[W-1:0];
      4'd9:  return p[2*W-1:W];
      4'd10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd11: return (b == 0) ? a : a % b;
`endif
      default: return b;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [W-1:0] b);
`ifdef SEQ_ALU_MULDIV_EN
    if (op == 4'd8 || op == 4'd9) return W;
    if ((op == 4'd10 || op == 4'd11) && b != 0) return W;
`endif
    return 1;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    alu_selector = op;
    in1 = a;
    in2 = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    alu_selector = '0;
    in1 = '0;
    in2 = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out !== '0) begin n_err++; $display("FAIL reset_out got %h want 0", out); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (zero !== 1'b1 || neg !== 1'b0) begin n_err++; $display("FAIL reset_flags got zero=%b neg=%b want zero=1 neg=0", zero, neg); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL release_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    out_ready = 1'b1;
    @(negedge clk);
    drive(4'd1, 32'd5, 32'd7); exp_q.push_back(model(4'd1, 32'd5, 32'd7));
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    @(negedge clk);
    drive(4'd7, 32'hFFFF_FFFF, 32'd1); exp_q.push_back(model(4'd7, 32'hFFFF_FFFF, 32'd1));
    e = exp_q.pop_front();
    n_cmp++; if (out_valid !== 1'b1 || out !== e) begin n_err++; $display("FAIL b2b_sub got v=%b %h want v=1 %h", out_valid, out, e); end
    n_cmp++; if (neg !== 1'b1) begin n_err++; $display("FAIL b2b_sub_neg got %b want 1", neg); end
    @(negedge clk);
    drive(4'd5, 32'hFFFF_FFFF, 32'd1); exp_q.push_back(model(4'd5, 32'hFFFF_FFFF, 32'd1));
    e = exp_q.pop_front();
    n_cmp++; if (out_valid !== 1'b1 || out !== e) begin n_err++; $display("FAIL b2b_slt got v=%b %h want v=1 %h", out_valid, out, e); end
    @(negedge clk);
    in_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (out_valid !== 1'b1 || out !== e) begin n_err++; $display("FAIL b2b_sltu got v=%b %h want v=1 %h", out_valid, out, e); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL b2b_sltu_zero got %b want 1", zero); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_muldiv();
    logic [3:0]   ops[7] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd10, 4'd11, 4'd8};
    logic [W-1:0] as[7]  = '{32'h1_0000, 32'h1_0000, 32'd100, 32'd100, 32'd9, 32'd9, 32'd6};
    logic [W-1:0] bs[7]  = '{32'h1_0000, 32'h1_0000, 32'd7, 32'd7, 32'd0, 32'd0, 32'd7};
    logic [W-1:0] e;
    int lat, bad;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(ops[i], as[i], bs[i]);
      exp_q.push_back(model(ops[i], as[i], bs[i]));
      lat = latency(ops[i], bs[i]);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL md%0d_accept got %b want 1", i, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      bad = 0;
      for (int k = 1; k < lat; k++) begin
        if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
        @(negedge clk);
      end
      if (lat > 1) begin
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL md%0d_busy got %0d bad cycles want 0", i, bad); end
      end
      e = exp_q.pop_front();
      n_cmp++; if (out_valid !== 1'b1 || out !== e) begin n_err++; $display("FAIL md%0d_result op=%0d got v=%b %h want v=1 %h", i, ops[i], out_valid, out, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e;
    out_ready = 1'b0;
    drive(4'd0, 32'd3, 32'd4); exp_q.push_back(model(4'd0, 32'd3, 32'd4));
    @(negedge clk);
    drive(4'd6, 32'h0000_00F0, 32'h0000_00FF);
    e = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (out_valid !== 1'b1 || out !== e) begin n_err++; $display("FAIL bp_hold%0d got v=%b %h want v=1 %h", c, out_valid, out, e); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready%0d got %b want 0", c, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out !== e) begin n_err++; $display("FAIL bp_release got rdy=%b %h want rdy=1 %h", in_ready, out, e); end
    exp_q.push_back(model(4'd6, 32'h0000_00F0, 32'h0000_00FF));
    @(negedge clk);
    in_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (out_valid !== 1'b1 || out !== e) begin n_err++; $display("FAIL bp_next got v=%b %h want v=1 %h", out_valid, out, e); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
`ifdef SEQ_ALU_MULDIV_EN
    int seen;
    out_ready = 1'b1;
    drive(4'd10, 32'd1000, 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out !== '0) begin n_err++; $display("FAIL abort_reset got v=%b %h want v=0 0", out_valid, out); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL abort_no_result got %0d valid cycles want 0", seen); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_idle got %b want 1", in_ready); end
`endif
  endtask

  task automatic test_random();
    localparam int N = 40;
    int sent = 0, got = 0, cyc = 0;
    bit fired = 0;
    logic [3:0] op;
    logic [W-1:0] a, b, e;
    in_valid = 1'b0;
    while (got < N && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (fired) in_valid = 1'b0;
      fired = 0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < N && $urandom_range(0, 2) != 0) begin
        op = 4'($urandom_range(0, 15));
        a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
        b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
        drive(op, a, b);
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL rnd_unexpected got %h want no output", out);
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if (out !== e) begin n_err++; $display("FAIL rnd_result%0d got %h want %h", got, out, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(alu_selector, in1, in2));
        sent++;
        fired = 1;
      end
    end
    if (got < N) begin
      n_cmp++; n_err++; $display("FAIL rnd_timeout got %0d results want %0d", got, N);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_muldiv();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
